fp_divider_seq: RTL
===================

Name: fp_divider_seq

Overview:
- Iterative single-precision divider: out = in0 / in1. Inverse operation of the team's combinational fp multipliers.
- Same simplified number format as those multipliers: hidden-1 mantissa, no denormals, no NaN handling, truncation with no rounding.
- Computes one quotient bit per clock (restoring division), using a start/busy/done handshake.
- Sits beside the multipliers in the floating library for datapaths that can tolerate multi-cycle latency.

Parameters:
- none (format fixed at 1/8/23; iteration count fixed at 25)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- in0  input  32  dividend, IEEE-754 single layout
- in1  input  32  divisor, IEEE-754 single layout
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; out valid
- out  output  32  quotient; held until next done
- dbz  output  1  divide-by-zero flag for the current out; held with out

Behaviour:
- Reset (async, rst_n=0): out=0, done=0, busy=0, dbz=0, state=IDLE, all internal registers cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC, NORM.
- IDLE: start=1 at cycle T captures in0/in1, sets busy=1 from T+1, and classifies the operands.
  - Normal operands: go to CALC with count=24, rem={1'b0,1,in0[22:0]}, dv={1,in1[22:0]}.
  - in1==32'b0 or in0==32'b0 (whole-word compare): go directly to NORM with the special flag set.
- CALC, one cycle per bit, count 24 down to 0:
  - if rem>=dv then q[count]=1 and rem=rem-dv, else q[count]=0;
  - then rem<<=1.
  - rem is 25 bits wide and must not overflow.
  - After count==0 go to NORM. CALC occupies T+1..T+25.
  - Result: q = floor(a_val*2^24/b_val), 25 bits; q[24]=1 iff a_val>=b_val.
- NORM, one cycle; registers out, dbz and done, clears busy, returns to IDLE.
  - z_sign = in0[31]^in1[31].
  - exp0 (10-bit two's complement) = a_exp - b_exp + 126 + q[24].
  - Mantissa = q[24] ? q[23:1] : q[22:0].
  - Normal case: out = {z_sign, exp0[7:0], mantissa}.
  - exp0 > 255: out = {z_sign, 8'hFF, 23'b0} (overflow saturates).
  - exp0 <= 0 (bit9 set, or zero): out = {z_sign, 31'b0} (flush to zero).
  - in1==0, regardless of in0: out = {z_sign, 8'hFF, 23'b0}, dbz=1.
  - in0==0, in1!=0: out = 32'b0, dbz=0.
- Timing, normal path: start at T; busy high T+1..T+26; done=1 and new out/dbz visible in T+27; busy=0 in T+27.
- Timing, special path: busy high T+1; done and out visible in T+2.
- start while busy=0 in the same cycle that done=1 is accepted (back-to-back operation). start while busy=1 is ignored, and in0/in1 changes then have no effect.
- done is a single-cycle pulse. out and dbz hold their values until the next NORM.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> done at T+27, out=0x40400000, dbz=0; busy high exactly 26 cycles.
- 0x3F800000 / 0x40400000 (1/3) -> out=0x3EAAAAAA (truncated, not 0x3EAAAAAB); then 0xBF800000 / 0x3F000000 back-to-back, start on the done cycle -> out=0xC0000000.
- 0x7F000000 / 0x3E800000 -> overflow, out=0x7F800000. 0x00800000 / 0x40000000 -> exp0=0, out=0x00000000.
- 0x3F800000 / 0x00000000 -> done at T+2, out=0x7F800000, dbz=1. 0x00000000 / 0x40000000 -> done at T+2, out=0x00000000, dbz=0.
- Start 6/2, pulse start with other operands at T+5 (ignored) -> still out=0x40400000 at T+27, single done.
- Start 6/2, assert rst_n=0 at T+10 -> busy/done/out/dbz zero immediately, no done afterwards. New start after release -> correct result at the normal latency.

Source files
------------

// File: rtl/fp_divider_seq.sv
// Iterative single-precision divider (1/8/23, hidden-1, no denormals, truncating).
// Restoring division, one quotient bit per clock, start/busy/done handshake.
module fp_divider_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [24:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic [4:0]  count_q, count_d;
    logic        special_q, special_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] out_q, out_d;
    logic        dbz_q, dbz_d;

    // Datapath terms used by CALC and NORM.
    logic [24:0] dv;
    logic        rem_ge;
    logic [24:0] rem_next;
    logic        z_sign;
    logic [9:0]  exp0;
    logic [22:0] mant;

    assign dv       = {2'b01, b_q[22:0]};
    assign rem_ge   = (rem_q >= dv);
    assign rem_next = rem_ge ? (rem_q - dv) : rem_q;
    assign z_sign   = a_q[31] ^ b_q[31];
    assign exp0     = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'd126 + {9'd0, quo_q[24]};
    assign mant     = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            count_q   <= '0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            count_q   <= count_d;
            special_q <= special_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            out_q     <= out_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        count_d   = count_q;
        special_d = special_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        out_d     = out_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = in0;
                    b_d    = in1;
                    busy_d = 1'b1;
                    quo_d  = '0;
                    if ((in0 == 32'd0) || (in1 == 32'd0)) begin
                        special_d = 1'b1;
                        state_d   = NORM;
                    end else begin
                        special_d = 1'b0;
                        rem_d     = {2'b01, in0[22:0]};
                        count_d   = 5'd24;
                        state_d   = CALC;
                    end
                end
            end

            CALC: begin
                // rem_next < dv < 2^24, so the shift never loses a set bit.
                rem_d   = {rem_next[23:0], 1'b0};
                quo_d   = {quo_q[23:0], rem_ge};
                count_d = count_q - 5'd1;
                if (count_q == 5'd0) begin
                    state_d = NORM;
                end
            end

            NORM: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                dbz_d   = 1'b0;
                if (special_q && (b_q == 32'd0)) begin
                    out_d = {z_sign, 8'hFF, 23'd0};
                    dbz_d = 1'b1;
                end else if (special_q) begin
                    out_d = 32'd0;
                end else if (exp0[9] || (exp0 == 10'd0)) begin
                    out_d = {z_sign, 31'd0};
                end else if (exp0[8]) begin
                    out_d = {z_sign, 8'hFF, 23'd0};
                end else begin
                    out_d = {z_sign, exp0[7:0], mant};
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign dbz  = dbz_q;

endmodule
